// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_arbiter_pkg : grant-state encoding and memory strobe levels
// Rev 1.0
// ----------------------------------------------------------------------------
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle   = 2'd0,
        ArbGntIf  = 2'd1,
        ArbGntDbg = 2'd2
    } arb_state_t;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

endpackage
`default_nettype wire

// File: rtl/imem_arb_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_arb_sel : next-grant and debug-burst decision for imem_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_arb_sel
    import imem_arbiter_pkg::*;
#(
    parameter int DBG_BURST_MAX = 4,
    parameter int BURST_W       = 3
) (
    input  arb_state_t         state,
    input  logic               dbg_halt,
    input  logic               if_req,
    input  logic               if_aligned,
    input  logic               dbg_req,
    input  logic [BURST_W-1:0] burst,
    output arb_state_t         next_state,
    output logic [BURST_W-1:0] next_burst,
    output logic               fetch_err
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(DBG_BURST_MAX);

    // A request whose access is on the memory port this cycle is still the
    // same request; it only becomes eligible again once its response is out.
    logic if_live;
    logic dbg_live;

    assign if_live  = if_req  & (state != ArbGntIf);
    assign dbg_live = dbg_req & (state != ArbGntDbg);

    always_comb begin
        next_state = ArbIdle;
        next_burst = burst;
        fetch_err  = 1'b0;
        if (dbg_halt) begin
            next_burst = '0;
            if (dbg_live) begin
                next_state = ArbGntDbg;
            end
        end else if (dbg_live && (!if_live || (burst < BURST_LIMIT))) begin
            next_state = ArbGntDbg;
            next_burst = if_live ? burst + 1'b1 : '0;
        end else if (if_live) begin
            if (if_aligned) begin
                next_state = ArbGntIf;
                next_burst = '0;
            end else begin
                fetch_err  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_arbiter : shares the single-port instruction memory between fetch/debug
// Rev 1.0
// ----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MEM_AW        = 17,
    parameter int DBG_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    output logic              stall_req,
    input  logic              dbg_halt,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int BURST_W = $clog2(DBG_BURST_MAX + 1);

    arb_state_t         state;
    arb_state_t         next_state;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] next_burst;
    logic               fetch_err;
    logic               if_aligned;
    logic               unused_addr_bits;

    assign if_aligned       = (if_addr[1:0] == 2'b00);
    assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2],
                                dbg_addr[ADDR_W-1:MEM_AW+2], dbg_addr[1:0]};

    imem_arb_sel #(
        .DBG_BURST_MAX (DBG_BURST_MAX),
        .BURST_W       (BURST_W)
    ) u_sel (
        .state      (state),
        .dbg_halt   (dbg_halt),
        .if_req     (if_req),
        .if_aligned (if_aligned),
        .dbg_req    (dbg_req),
        .burst      (burst),
        .next_state (next_state),
        .next_burst (next_burst),
        .fetch_err  (fetch_err)
    );

    // Held low in reset so ctrl never sees a stall from an aborted fetch.
    assign stall_req = rst & if_req & (next_state != ArbGntIf) & ~if_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ArbIdle;
            burst     <= '0;
            mem_ce    <= ChipDisable;
            mem_we    <= WriteDisable;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            state  <= next_state;
            burst  <= next_burst;
            mem_ce <= (next_state != ArbIdle) ? ChipEnable : ChipDisable;
            mem_we <= ((next_state == ArbGntDbg) && dbg_we) ? WriteEnable : WriteDisable;
            if (next_state == ArbGntIf) begin
                mem_addr  <= if_addr[MEM_AW+1:2];
            end else if (next_state == ArbGntDbg) begin
                mem_addr  <= dbg_addr[MEM_AW+1:2];
                mem_wdata <= dbg_wdata;
            end
            // Responses are the registered image of the cycle just granted.
            if_rvalid <= (state == ArbGntIf);
            dbg_ack   <= (state == ArbGntDbg);
            if_err    <= fetch_err;
            if (state == ArbGntIf) begin
                if_rdata  <= mem_rdata;
            end
            if ((state == ArbGntDbg) && !mem_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_arbiter : directed and random checks of imem_arbiter against a model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int ADDR_W        = 32;
    localparam int MEM_AW        = 17;
    localparam int DBG_BURST_MAX = 4;
    localparam int K_NONE        = 0;
    localparam int K_IF          = 1;
    localparam int K_DBG         = 2;
    localparam int K_ERR         = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } dreq_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;
    logic              stall_req;
    logic              dbg_halt = 1'b0;
    logic              dbg_req = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [31:0]       dbg_wdata = '0;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;
    logic              mem_ce;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    imem_arbiter #(
        .ADDR_W        (ADDR_W),
        .MEM_AW        (MEM_AW),
        .DBG_BURST_MAX (DBG_BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .stall_req (stall_req),
        .dbg_halt  (dbg_halt),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hC3, b, ~b, 8'h3C};
    endfunction

    // Behavioural single-port memory (256 words are enough for the bench).
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = pat(i);
        forever begin
            @(posedge clk);
            if (mem_ce && mem_we) mem[mem_addr[7:0]] = mem_wdata;
        end
    end

    // Reference state: what the arbiter should have decided and what is
    // occupying the memory port, tracked as transactions.
    logic [31:0] ref_mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_kind = K_NONE;
    int          dec_kind = K_NONE;
    logic [7:0]  acc_idx = '0, dec_idx = '0;
    logic        acc_we = 1'b0, dec_we = 1'b0;
    logic [31:0] acc_wd = '0, dec_wd = '0;
    int          burst_m = 0;
    logic        exp_rv = 1'b0, exp_err = 1'b0, exp_ack = 1'b0;
    logic [31:0] exp_ifd = '0, exp_dbd = '0;
    logic        f_busy = 1'b0, d_busy = 1'b0, halt_v = 1'b0;
    logic [31:0] f_addr = '0, d_addr_v = '0, d_wd_v = '0;
    logic        d_we_v = 1'b0;
    int          f_pct = 0, d_pct = 0, mis_pct = 0, halt_pct = 0;
    logic [31:0] fq [$];
    dreq_t       dq [$];
    int          cnt_rv = 0, cnt_ack = 0, cnt_ce = 0, cnt_exp_rv = 0, cnt_exp_ack = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, "_if_err"},    32'(if_err),    32'd0);
        chk({tag, "_dbg_ack"},   32'(dbg_ack),   32'd0);
        chk({tag, "_mem_ce"},    32'(mem_ce),    32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_if_rdata"},  if_rdata,       32'd0);
        chk({tag, "_dbg_rdata"}, dbg_rdata,      32'd0);
        chk({tag, "_stall_req"}, 32'(stall_req), 32'd0);
    endtask

    function automatic logic [31:0] mk_addr(input logic [7:0] w, input logic [1:0] b);
        logic [12:0] junk;
        junk = 13'($urandom);
        return {junk, 9'd0, w, b};
    endfunction

    task automatic issue_fetch();
        logic [1:0] b;
        if (fq.size() > 0) begin
            f_addr = fq.pop_front();
            f_busy = 1'b1;
        end else if (int'($urandom_range(99)) < f_pct) begin
            b = (int'($urandom_range(99)) < mis_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
            f_addr = mk_addr(8'($urandom), b);
            f_busy = 1'b1;
        end
    endtask

    task automatic issue_dbg();
        dreq_t r;
        if (dq.size() > 0) begin
            r = dq.pop_front();
            d_we_v = r.we; d_addr_v = r.addr; d_wd_v = r.wd;
            d_busy = 1'b1;
        end else if (int'($urandom_range(99)) < d_pct) begin
            d_we_v   = 1'($urandom);
            d_addr_v = mk_addr(8'($urandom), 2'($urandom));
            d_wd_v   = $urandom;
            d_busy   = 1'b1;
        end
    endtask

    // Effects of the clock edge just passed, then compare every output.
    task automatic edge_update();
        exp_rv  = (acc_kind == K_IF);
        exp_ack = (acc_kind == K_DBG);
        exp_err = (dec_kind == K_ERR);
        if (acc_kind == K_IF) exp_ifd = ref_mem[acc_idx];
        if (acc_kind == K_DBG) begin
            if (acc_we) ref_mem[acc_idx] = acc_wd;
            else        exp_dbd = ref_mem[acc_idx];
        end
        acc_kind = (dec_kind == K_IF || dec_kind == K_DBG) ? dec_kind : K_NONE;
        acc_idx  = dec_idx;
        acc_we   = dec_we;
        acc_wd   = dec_wd;
        chk("if_rvalid", 32'(if_rvalid), 32'(exp_rv));
        chk("if_err",    32'(if_err),    32'(exp_err));
        chk("dbg_ack",   32'(dbg_ack),   32'(exp_ack));
        chk("if_rdata",  if_rdata,       exp_ifd);
        chk("dbg_rdata", dbg_rdata,      exp_dbd);
        chk("mem_ce",    32'(mem_ce),    32'(acc_kind != K_NONE));
        chk("mem_we",    32'(mem_we),    32'(acc_kind == K_DBG && acc_we));
        if (acc_kind != K_NONE) chk("mem_addr", 32'(mem_addr), 32'(acc_idx));
        if (acc_kind == K_DBG && acc_we) chk("mem_wdata", mem_wdata, acc_wd);
        cnt_rv      += int'(if_rvalid);
        cnt_ack     += int'(dbg_ack);
        cnt_ce      += int'(mem_ce);
        cnt_exp_rv  += int'(exp_rv);
        cnt_exp_ack += int'(exp_ack);
    endtask

    // Requesters react to their responses, inputs are driven, and the
    // arbitration rules pick who owns the memory next cycle.
    task automatic drive_and_decide();
        logic fe, de;
        if (exp_rv || exp_err) f_busy = 1'b0;
        if (exp_ack) d_busy = 1'b0;
        if (!f_busy) issue_fetch();
        if (!d_busy) issue_dbg();
        if (int'($urandom_range(99)) < halt_pct) halt_v = ~halt_v;
        if_req = f_busy;  if_addr = f_addr;
        dbg_req = d_busy; dbg_we = d_we_v; dbg_addr = d_addr_v; dbg_wdata = d_wd_v;
        dbg_halt = halt_v;
        fe = f_busy && (acc_kind != K_IF);
        de = d_busy && (acc_kind != K_DBG);
        dec_kind = K_NONE;
        if (halt_v) begin
            burst_m = 0;
            if (de) dec_kind = K_DBG;
        end else if (de && (!fe || burst_m < DBG_BURST_MAX)) begin
            dec_kind = K_DBG;
            burst_m  = fe ? burst_m + 1 : 0;
        end else if (fe) begin
            if (f_addr[1:0] == 2'b00) begin
                dec_kind = K_IF;
                burst_m  = 0;
            end else begin
                dec_kind = K_ERR;
            end
        end
        dec_idx = (dec_kind == K_DBG) ? d_addr_v[9:2] : f_addr[9:2];
        dec_we  = (dec_kind == K_DBG) && d_we_v;
        dec_wd  = d_wd_v;
        #1;
        chk("stall_req", 32'(stall_req), 32'(f_busy && dec_kind != K_IF && !exp_rv));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_update();
        drive_and_decide();
    endtask

    task automatic model_reset();
        acc_kind = K_NONE; dec_kind = K_NONE; burst_m = 0;
        exp_rv = 1'b0; exp_err = 1'b0; exp_ack = 1'b0;
        exp_ifd = '0; exp_dbd = '0;
        f_busy = 1'b0; d_busy = 1'b0; halt_v = 1'b0;
        fq.delete(); dq.delete();
        if_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_halt = 1'b0;
    endtask

    initial begin
        int c_ack, c_rv, c_ce, c_erv, c_eack;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        // Reset with both requesters pushing: everything stays quiet.
        if_req = 1'b1; if_addr = 32'h8; dbg_req = 1'b1; dbg_we = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_and_decide();

        // Single fetch of 0x8.
        fq.push_back(32'h0000_0008);
        tick();
        tick();
        chk("fetch_mem_ce",   32'(mem_ce),    32'd1);
        chk("fetch_mem_addr", 32'(mem_addr),  32'd2);
        chk("fetch_wait_stall", 32'(stall_req), 32'd1);
        tick();
        chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
        chk("fetch_rdata",  if_rdata,       pat(2));
        chk("fetch_done_stall", 32'(stall_req), 32'd0);

        // Loader halt: debug write goes through, fetch stays stalled.
        halt_v = 1'b1;
        dq.push_back('{we: 1'b1, addr: 32'h14, wd: 32'h0422_2821});
        fq.push_back(32'h0000_0020);
        tick();
        tick();
        chk("halt_mem_we",    32'(mem_we),    32'd1);
        chk("halt_mem_addr",  32'(mem_addr),  32'd5);
        chk("halt_mem_wdata", mem_wdata,      32'h0422_2821);
        chk("halt_stall_a",   32'(stall_req), 32'd1);
        tick();
        chk("halt_dbg_ack",   32'(dbg_ack),   32'd1);
        chk("halt_no_rvalid", 32'(if_rvalid), 32'd0);
        chk("halt_stall_b",   32'(stall_req), 32'd1);
        tick();
        tick();
        chk("halt_mem_idle", 32'(mem_ce),    32'd0);
        chk("halt_stall_c",  32'(stall_req), 32'd1);
        halt_v = 1'b0;
        tick();
        tick();
        tick();
        chk("unhalt_rvalid", 32'(if_rvalid), 32'd1);
        chk("unhalt_rdata",  if_rdata,       pat(8));

        // Misaligned fetch is rejected without touching memory.
        fq.push_back(32'h0000_0006);
        tick();
        chk("mis_stall", 32'(stall_req), 32'd1);
        tick();
        chk("mis_err",    32'(if_err),    32'd1);
        chk("mis_mem_ce", 32'(mem_ce),    32'd0);
        chk("mis_rvalid", 32'(if_rvalid), 32'd0);
        tick();
        chk("mis_err_pulse", 32'(if_err), 32'd0);

        // Debug write then read back.
        c_ack = cnt_ack;
        dq.push_back('{we: 1'b1, addr: 32'h40, wd: 32'hDEAD_BEEF});
        dq.push_back('{we: 1'b0, addr: 32'h40, wd: 32'h0});
        repeat (5) tick();
        chk("wr_rd_ack",   32'(dbg_ack), 32'd1);
        chk("wr_rd_rdata", dbg_rdata,    32'hDEAD_BEEF);
        chk("wr_rd_acks",  32'(cnt_ack - c_ack), 32'd2);

        // Both requesters saturating: memory busy every cycle.
        f_pct = 100; d_pct = 100; mis_pct = 0;
        repeat (4) tick();
        c_ack = cnt_ack; c_rv = cnt_rv; c_ce = cnt_ce; c_eack = cnt_exp_ack; c_erv = cnt_exp_rv;
        repeat (20) tick();
        chk("sat_ce_cycles", 32'(cnt_ce - c_ce),   32'd20);
        chk("sat_dbg_acks",  32'(cnt_ack - c_ack), 32'(cnt_exp_ack - c_eack));
        chk("sat_if_rvalid", 32'(cnt_rv - c_rv),   32'(cnt_exp_rv - c_erv));

        // Random traffic with halt toggling.
        f_pct = 40; d_pct = 40; mis_pct = 15; halt_pct = 4;
        repeat (1500) tick();
        f_pct = 0; d_pct = 0; halt_pct = 0; halt_v = 1'b0;
        repeat (8) tick();

        // Reset in the middle of a debug write.
        dq.push_back('{we: 1'b1, addr: 32'h80, wd: 32'h1234_5678});
        tick();
        tick();
        chk("rstmid_we_before", 32'(mem_we), 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rstmid_we_drop", 32'(mem_we), 32'd0);
        chk("rstmid_ce_drop", 32'(mem_ce), 32'd0);
        @(posedge clk);
        #1;
        chk_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b1;
        drive_and_decide();
        dq.push_back('{we: 1'b0, addr: 32'h80, wd: 32'h0});
        repeat (3) tick();
        chk("rstmid_ack",     32'(dbg_ack), 32'd1);
        chk("rstmid_no_write", dbg_rdata,   pat(32));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
